// File: rtl/mig_burst_pkg.sv
// rtl/mig_burst_pkg.sv - shared state, mode and command codes for the MIG burst engine
package mig_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_WRITE,
        ST_READ,
        ST_READ_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_WRITE   = 2'd0;
    localparam logic [1:0] MODE_READ    = 2'd1;
    localparam logic [1:0] MODE_WRV     = 2'd2;
    localparam logic [1:0] MODE_WRV_ALT = 2'd3;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_pattern_gen.sv
// rtl/mig_pattern_gen.sv - incrementing data pattern: seed load, step on each consumed beat
module mig_pattern_gen #(
    parameter int DATA_W   = 256,
    parameter int PAT_STEP = 2
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    // Current beat's pattern; reloaded at burst start, stepped after each consumed beat
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= value + DATA_W'(PAT_STEP);
        end
    end

endmodule

// File: rtl/mig_burst_engine.sv
// rtl/mig_burst_engine.sv - MIG app-interface burst engine (write/read/write-verify); MIG_BURST_VERIFY_EN adds read-back compare
module mig_burst_engine
    import mig_burst_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 8,
    parameter int PAT_STEP  = 2
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [DATA_W-1:0]   pat_seed,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   err_addr
);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         mode_q;
    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   wdf_cnt;
    logic [LEN_W-1:0]   cmd_cnt;
    logic [LEN_W-1:0]   ret_cnt;
    logic [LEN_W-1:0]   wdf_nxt;
    logic [LEN_W-1:0]   cmd_nxt;
    logic [LEN_W-1:0]   ret_nxt;
    logic               wdf_xfer;
    logic               cmd_xfer;
    logic               rd_beat;
    logic               pat_load;
    logic               phase_start;

    assign wdf_xfer     = app_wdf_wren & app_wdf_rdy;
    assign cmd_xfer     = app_en & app_rdy;
    assign rd_beat      = app_rd_data_valid & ((state == ST_READ) | (state == ST_READ_WAIT));
    assign pat_load     = (state == ST_IDLE) & start;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    mig_pattern_gen #(
        .DATA_W   (DATA_W),
        .PAT_STEP (PAT_STEP)
    ) u_wr_gen (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .load            (pat_load),
        .seed            (pat_seed),
        .advance         (wdf_xfer),
        .value           (app_wdf_data)
    );

    // Next state and next counter values; outputs are registered from these
    always_comb begin
        state_nxt   = state;
        wdf_nxt     = wdf_cnt + LEN_W'(wdf_xfer);
        cmd_nxt     = cmd_cnt + LEN_W'(cmd_xfer);
        ret_nxt     = ret_cnt + LEN_W'(rd_beat);
        phase_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT_CAL;
                    wdf_nxt   = '0;
                    cmd_nxt   = '0;
                    ret_nxt   = '0;
                end
            end
            ST_WAIT_CAL: begin
                if (init_calib_complete) begin
                    phase_start = 1'b1;
                    if (len_q == '0) begin
                        state_nxt = ST_DONE;
                    end else if (mode_q == MODE_READ) begin
                        state_nxt = ST_READ;
                    end else begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if ((cmd_cnt == len_q) && (wdf_cnt == len_q)) begin
                    if (mode_q == MODE_WRITE) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt   = ST_READ;
                        phase_start = 1'b1;
                        wdf_nxt     = '0;
                        cmd_nxt     = '0;
                        ret_nxt     = '0;
                    end
                end
            end
            ST_READ: begin
                if (cmd_cnt == len_q) begin
                    state_nxt = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (ret_nxt == len_q) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst FSM: latches the request, tracks progress and registers every app-side output
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_WRITE;
            base_q       <= '0;
            len_q        <= '0;
            wdf_cnt      <= '0;
            cmd_cnt      <= '0;
            ret_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_cmd      <= CMD_WRITE;
            app_addr     <= '0;
        end else begin
            state   <= state_nxt;
            wdf_cnt <= wdf_nxt;
            cmd_cnt <= cmd_nxt;
            ret_cnt <= ret_nxt;
            if (pat_load) begin
                mode_q <= (mode == MODE_WRV_ALT) ? MODE_WRV : mode;
                base_q <= base_addr;
                len_q  <= burst_len;
            end
            busy         <= (state_nxt != ST_IDLE);
            done         <= (state_nxt == ST_DONE);
            // data is offered ahead of its command so a command never outruns its beat
            app_wdf_wren <= (state_nxt == ST_WRITE) && (wdf_nxt < len_q);
            app_en       <= ((state_nxt == ST_WRITE) && (cmd_nxt < wdf_nxt)) ||
                            ((state_nxt == ST_READ) && (cmd_nxt < len_q));
            app_cmd      <= (state_nxt == ST_READ) ? CMD_READ : CMD_WRITE;
            if (phase_start) begin
                app_addr <= base_q;
            end else if (cmd_xfer) begin
                app_addr <= app_addr + ADDR_W'(ADDR_STEP);
            end
        end
    end

    // Forward every returned read beat one cycle later, in or out of a burst
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= app_rd_data_valid;
            if (app_rd_data_valid) begin
                rd_data <= app_rd_data;
            end
        end
    end

`ifdef MIG_BURST_VERIFY_EN
    logic [DATA_W-1:0] exp_data;
    logic              chk_beat;
    logic              mismatch;

    // only the read phase of a write-then-verify burst is scored
    assign chk_beat = rd_beat & (mode_q == MODE_WRV);
    assign mismatch = chk_beat & (app_rd_data != exp_data);

    mig_pattern_gen #(
        .DATA_W   (DATA_W),
        .PAT_STEP (PAT_STEP)
    ) u_exp_gen (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .load            (pat_load),
        .seed            (pat_seed),
        .advance         (chk_beat),
        .value           (exp_data)
    );

    // Saturating error count; the first failing beat pins the reported address
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (pat_load) begin
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (mismatch) begin
            if (err_cnt == '0) begin
                err_addr <= base_q + ADDR_W'(ret_cnt) * ADDR_W'(ADDR_STEP);
            end
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign err_cnt  = '0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_mig_burst_engine.sv
// tb/tb_mig_burst_engine.sv - self-checking bench for mig_burst_engine with a behavioural MIG memory model
`timescale 1ns/1ps
module tb_mig_burst_engine;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;
`ifdef MIG_BURST_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic                ui_clk;
    logic                ui_clk_sync_rst;
    logic                init_calib_complete;
    logic                start;
    logic [1:0]          mode;
    logic [ADDR_W-1:0]   base_addr;
    logic [LEN_W-1:0]    burst_len;
    logic [DATA_W-1:0]   pat_seed;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic [15:0]         err_cnt;
    logic [ADDR_W-1:0]   err_addr;

    mig_burst_engine dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .start               (start),
        .mode                (mode),
        .base_addr           (base_addr),
        .burst_len           (burst_len),
        .pat_seed            (pat_seed),
        .busy                (busy),
        .done                (done),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .err_cnt             (err_cnt),
        .err_addr            (err_addr)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        int                due;
    } ret_t;

    int n_checks;
    int n_pass;
    int cyc;

    // burst parameters, written by the stimulus process only
    logic [DATA_W-1:0] cur_seed;
    logic [ADDR_W-1:0] cur_base;
    int                corrupt_idx;
    bit                stall_en;
    bit                cur_verify;

    // model state, written by the monitor process only
    int                n_wd, n_wc, n_rc, n_ret, n_done, err_model;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] q_wdata [$];
    logic [ADDR_W-1:0] q_waddr [$];
    logic [DATA_W-1:0] q_rdfwd [$];
    ret_t              retq [$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    bit                prev_rv;
    logic [DATA_W-1:0] prev_rd;

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(negedge ui_clk);
        #1;
    endtask

    initial begin
        ui_clk = 1'b0;
        forever #5 ui_clk = ~ui_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge ui_clk);
            cyc++;
        end
    end

    // Memory model and per-cycle compare of app-side traffic and the read forward path
    initial begin
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        ret_t              r;
        int                wd_before;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        n_wd = 0; n_wc = 0; n_rc = 0; n_ret = 0; n_done = 0; err_model = 0;
        first_err_addr = '0; prev_rv = 1'b0; prev_rd = '0;
        forever begin
            @(negedge ui_clk);
            if (ui_clk_sync_rst) begin
                retq.delete();
                prev_rv = 1'b0;
                app_rd_data_valid = 1'b0;
                app_rdy = 1'b1;
                app_wdf_rdy = 1'b1;
            end else begin
                if (start) begin
                    n_wd = 0; n_wc = 0; n_rc = 0; n_ret = 0; err_model = 0; first_err_addr = '0;
                    q_wdata.delete(); q_waddr.delete(); q_rdfwd.delete(); retq.delete(); mem.delete();
                end
                wd_before = n_wd;
                app_rdy     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                app_wdf_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (app_wdf_wren && app_wdf_rdy) begin
                    check("wdf_data", app_wdf_data, cur_seed + DATA_W'(2 * n_wd));
                    check("wdf_end", app_wdf_end, 1);
                    check("wdf_mask", app_wdf_mask, 0);
                    q_wdata.push_back(app_wdf_data);
                    n_wd++;
                end
                if (app_en && app_rdy) begin
                    a = app_addr;
                    if (app_cmd == 3'b000) begin
                        check("wr_addr", app_addr, ADDR_W'(cur_base + 8 * n_wc));
                        check("cmd_after_data", (n_wc < wd_before), 1);
                        if (n_wc < q_wdata.size()) mem[a] = q_wdata[n_wc];
                        q_waddr.push_back(a);
                        n_wc++;
                    end else begin
                        check("rd_cmd", app_cmd, 3'b001);
                        check("rd_addr", app_addr, ADDR_W'(cur_base + 8 * n_rc));
                        d = mem.exists(a) ? mem[a] : DATA_W'(a);
                        if (n_rc == corrupt_idx) d = d ^ DATA_W'(1);
                        r.d = d;
                        r.due = cyc + 3;
                        retq.push_back(r);
                        n_rc++;
                    end
                end
                check("rd_valid", rd_valid, prev_rv);
                if (prev_rv) begin
                    check("rd_data", rd_data, prev_rd);
                    q_rdfwd.push_back(rd_data);
                end
                if (retq.size() > 0 && retq[0].due <= cyc && (!stall_en || $urandom_range(0, 1) == 1)) begin
                    r = retq.pop_front();
                    app_rd_data_valid = 1'b1;
                    app_rd_data = r.d;
                    if (cur_verify && r.d != cur_seed + DATA_W'(2 * n_ret)) begin
                        if (err_model == 0) first_err_addr = ADDR_W'(cur_base + 8 * n_ret);
                        err_model++;
                    end
                    n_ret++;
                end else begin
                    app_rd_data_valid = 1'b0;
                    app_rd_data = {DATA_W/32{32'hDEADBEEF}};
                end
                prev_rv = app_rd_data_valid;
                prev_rd = app_rd_data;
                if (done) begin
                    n_done++;
                    check("busy_with_done", busy, 1);
                end
            end
        end
    end

    task automatic kick(input logic [1:0] m, input logic [ADDR_W-1:0] b, input int len,
                        input logic [DATA_W-1:0] s, input int cidx, input bit st);
        cur_seed = s; cur_base = b; corrupt_idx = cidx; stall_en = st; cur_verify = (m >= 2'd2);
        mode = m; base_addr = b; burst_len = LEN_W'(len); pat_seed = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        int k;
        k = 0;
        while (n_done < want && k < budget) begin
            tick();
            k++;
        end
        check("done_in_budget", (n_done >= want), 1);
        repeat (6) tick();
        check("done_once", n_done, want);
        check("busy_after", busy, 0);
    endtask

    task automatic check_fwd_5_7_9_11();
        check("fwd_count", q_rdfwd.size(), 4);
        if (q_rdfwd.size() == 4) begin
            check("fwd0", q_rdfwd[0], 5);
            check("fwd1", q_rdfwd[1], 7);
            check("fwd2", q_rdfwd[2], 9);
            check("fwd3", q_rdfwd[3], 11);
        end
    endtask

    initial begin
        int nd0;
        int k;
        n_checks = 0; n_pass = 0;
        cur_seed = '0; cur_base = '0; corrupt_idx = -1; stall_en = 1'b0; cur_verify = 1'b0;
        ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0; start = 1'b0;
        mode = 2'd0; base_addr = '0; burst_len = '0; pat_seed = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_app_cmd", app_cmd, 0);
        check("rst_app_addr", app_addr, 0);
        check("rst_wdf_data", app_wdf_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_addr", err_addr, 0);
        ui_clk_sync_rst = 1'b0;
        repeat (2) tick();

        // zero-length burst while calibration is still pending
        nd0 = n_done;
        kick(2'd0, '0, 0, '0, -1, 1'b0);
        repeat (4) tick();
        check("cal_wait_busy", busy, 1);
        check("cal_wait_no_done", n_done, nd0);
        init_calib_complete = 1'b1;
        wait_done(nd0 + 1, 50);
        check("len0_wd", n_wd, 0);
        check("len0_wc", n_wc, 0);
        check("len0_rc", n_rc, 0);

        // mode 0, base 0, len 10, seed 0 with start-to-traffic latency
        nd0 = n_done;
        kick(2'd0, '0, 10, '0, -1, 1'b0);
        check("lat_busy_t1", busy, 1);
        check("lat_wren_t1", app_wdf_wren, 0);
        tick();
        check("lat_wren_t2", app_wdf_wren, 1);
        check("lat_en_t2", app_en, 0);
        tick();
        check("lat_en_t3", app_en, 1);
        wait_done(nd0 + 1, 200);
        check("m0_wd", n_wd, 10);
        check("m0_wc", n_wc, 10);
        check("m0_rc", n_rc, 0);
        if (n_wd == 10 && n_wc == 10) begin
            check("m0_data1", q_wdata[1], 2);
            check("m0_data9", q_wdata[9], 18);
            check("m0_addr0", q_waddr[0], 0);
            check("m0_addr9", q_waddr[9], 72);
        end

        // mode 2, len 4, seed 5, echo memory
        nd0 = n_done;
        kick(2'd2, '0, 4, DATA_W'(5), -1, 1'b0);
        wait_done(nd0 + 1, 200);
        check_fwd_5_7_9_11();
        check("m2_err_cnt", err_cnt, 0);
        check("m2_err_model", err_model, 0);

        // mode 2 with beat 2 corrupted, base 0x100
        nd0 = n_done;
        kick(2'd2, ADDR_W'(32'h100), 4, DATA_W'(5), 2, 1'b0);
        wait_done(nd0 + 1, 200);
        check("corr_err_model", err_model, 1);
        check("corr_model_addr", first_err_addr, 32'h110);
        check("corr_err_cnt", err_cnt, VERIFY ? 1 : 0);
        check("corr_err_addr", err_addr, VERIFY ? 32'h110 : 0);

        // random stalls on both readies and on read returns, len 64
        nd0 = n_done;
        kick(2'd2, ADDR_W'(32'h40), 64, DATA_W'(32'h1234), -1, 1'b1);
        wait_done(nd0 + 1, 3000);
        stall_en = 1'b0;
        check("stall_wd", n_wd, 64);
        check("stall_wc", n_wc, 64);
        check("stall_rc", n_rc, 64);
        check("stall_ret", n_ret, 64);
        check("stall_fwd", q_rdfwd.size(), 64);
        check("stall_err_cnt", err_cnt, 0);

        // address wrap at the top of the space
        nd0 = n_done;
        kick(2'd0, ADDR_W'(32'h1FFFFFF8), 2, DATA_W'(7), -1, 1'b0);
        wait_done(nd0 + 1, 100);
        check("wrap_wc", n_wc, 2);
        if (n_wc == 2) begin
            check("wrap_addr0", q_waddr[0], 32'h1FFFFFF8);
            check("wrap_addr1", q_waddr[1], 0);
        end

        // reset at beat 3 of 10, then a fresh verify burst
        kick(2'd0, '0, 10, '0, -1, 1'b0);
        k = 0;
        while (n_wd < 3 && k < 50) begin
            tick();
            k++;
        end
        check("reach_beat3", (n_wd >= 3), 1);
        ui_clk_sync_rst = 1'b1;
        @(posedge ui_clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wren", app_wdf_wren, 0);
        check("mid_rst_en", app_en, 0);
        check("mid_rst_addr", app_addr, 0);
        check("mid_rst_cmd", app_cmd, 0);
        check("mid_rst_wdata", app_wdf_data, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        tick();
        ui_clk_sync_rst = 1'b0;
        repeat (2) tick();
        nd0 = n_done;
        kick(2'd3, '0, 4, DATA_W'(5), -1, 1'b0);
        wait_done(nd0 + 1, 200);
        check("post_rst_wd", n_wd, 4);
        check_fwd_5_7_9_11();
        check("post_rst_err_cnt", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mig_burst_engine.md
# mig_burst_engine

Parametrised traffic engine on the MIG 7-series user (app) interface, in the `ui_clk` domain between application logic and the MIG core. One `start` runs a burst of N commands in one of three modes: write, read, or write-then-verify. Write data comes from an incrementing pattern generator. Read data is forwarded in order, and in verify builds it is compared against the regenerated pattern with error reporting. Unlike the fixed 10-beat test FSM, the engine has independent command/data handshakes, runtime length/base/seed and exact completion tracking.

## Interface
- `ADDR_W`, 29, MIG `app_addr` width
- `DATA_W`, 256, `app_wdf_data`/`app_rd_data` width
- `LEN_W`, 16, burst-length counter width
- `ADDR_STEP`, 8, address increment per command (BL8 × x32)
- `PAT_STEP`, 2, pattern increment per beat
- `ui_clk`  in  1  clock
- `ui_clk_sync_rst`  in  1  asynchronous, active-high reset
- `init_calib_complete`  in  1  MIG calibration done
- `start`  in  1  one-cycle request, sampled in IDLE only
- `mode`  in  2  0 write, 1 read, 2 write-then-verify (3 treated as 2)
- `base_addr`  in  ADDR_W  first address
- `burst_len`  in  LEN_W  commands per phase
- `pat_seed`  in  DATA_W  pattern value for beat 0
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle completion pulse
- `app_addr`  out  ADDR_W, `app_cmd` out 3 (000 write, 001 read), `app_en` out 1, `app_rdy` in 1
- `app_wdf_data` out DATA_W, `app_wdf_wren` out 1, `app_wdf_end` out 1 (= `app_wdf_wren`), `app_wdf_mask` out DATA_W/8 (all 0), `app_wdf_rdy` in 1
- `app_rd_data` in DATA_W, `app_rd_data_valid` in 1
- `rd_data` out DATA_W, `rd_valid` out 1: registered forward of read beats
- `err_cnt` out 16, `err_addr` out ADDR_W: verify status (see Configuration)

## Operation
- States: IDLE, WAIT_CAL, WRITE, READ, READ_WAIT, DONE.
- IDLE + `start`:
  - latch base, len, seed, mode.
  - clear counters and `err_cnt`.
  - go to WAIT_CAL.
- WAIT_CAL → WRITE (mode 0/2) or READ (mode 1) when `init_calib_complete`.
- `burst_len` = 0 → DONE directly from WAIT_CAL; no app traffic.
- WRITE:
  - `wdf_cnt` counts data beats; transfer = `app_wdf_wren & app_wdf_rdy`.
  - `cmd_cnt` counts commands; transfer = `app_en & app_rdy`.
  - `app_wdf_wren` = (`wdf_cnt` < len).
  - `app_en` = (`cmd_cnt` < `wdf_cnt`), so data strictly leads its command.
  - Beat k data = seed + k·PAT_STEP (mod 2^DATA_W).
  - Command k address = base + k·ADDR_STEP (mod 2^ADDR_W, wraps silently).
  - Exit when `cmd_cnt` = `wdf_cnt` = len: mode 0 → DONE; mode 2 → READ with all counters cleared.
- READ:
  - `app_en` while `cmd_cnt` < len, `app_cmd` = 001, same address rule.
  - All commands issued → READ_WAIT.
- READ and READ_WAIT: each `app_rd_data_valid` increments `ret_cnt`.
- READ_WAIT → DONE when `ret_cnt` = len, including a return in the same cycle.
- DONE: `done` = 1 for one cycle, then IDLE.
- `app_en`/`app_wdf_wren` never depend combinationally on `app_rdy`/`app_wdf_rdy`.
- Outputs hold value while not ready.
- `app_rd_data_valid` outside READ/READ_WAIT: forwarded on `rd_valid`, neither counted nor compared.
- `start` while busy: ignored.

## Timing
- Reset values: state IDLE, all counters 0, `busy`/`done`/`app_en`/`app_wdf_wren`/`rd_valid` 0, `app_cmd` 000, `app_addr` 0, `app_wdf_data` 0, `err_cnt` 0, `err_addr` 0.
- Reset mid-burst returns to IDLE immediately; in-flight MIG reads after reset are forwarded only.
- `start` at cycle t → `busy` at t+1. With calibration already done, first `app_wdf_wren` at t+2 and first `app_en` at t+3 at the earliest.
- With both readies held high: one write beat and one command per cycle.
- `rd_valid`/`rd_data`: 1-cycle latency from `app_rd_data_valid`.
- `done` asserts the cycle after the exit condition. `busy` drops together with `done` falling.

## Configuration
- `MIG_BURST_VERIFY_EN` defined:
  - In mode 2 read phase, each returned beat j is compared with seed + j·PAT_STEP.
  - On mismatch: `err_cnt` increments, saturating at 0xFFFF.
  - First mismatch only: `err_addr` ← base + j·ADDR_STEP.
  - Comparison result is registered and takes effect 1 cycle after the beat.
- `MIG_BURST_VERIFY_EN` undefined:
  - Comparator and expected-pattern counter are absent.
  - `err_cnt` and `err_addr` are tied to 0.
  - Mode 2 still performs write then read.

## Structure
- Package `mig_burst_pkg`:
  - state enum.
  - mode codes.
  - `CMD_WRITE` = 3'b000, `CMD_READ` = 3'b001.
- One sub-module, `mig_pattern_gen`:
  - seed load, step-and-advance.
  - Instantiated for write data and, in verify builds, for expected read data.

## Test plan
- Mode 0, base 0, len 10, seed 0, readies high → 10 writes at addresses 0..72 step 8, data 0..18 step 2; `done` once.
- Mode 2, len 4, seed 5, memory model echoes → rd_data 5,7,9,11; `err_cnt` 0.
- Mode 2 with model corrupting beat 2, base 0x100 → `err_cnt` 1, `err_addr` 0x110.
- Random `app_rdy`/`app_wdf_rdy` stalls, len 64 → never command before its data, exactly 64 of each, no duplicates.
- `burst_len` 0; and base 0x1FFFFFF8, len 2 → no traffic/`done` pulse; second address wraps to 0.
- Reset asserted at beat 3 of 10 → all outputs at reset values next edge; a fresh start completes normally.
